// File: rtl/regfile_seq_pkg.sv
// Shared types and LFSR tap constants for the register-file sequencer.
// REGFILE_SEQ_REG0_CHECK_EN adds the ZW state to the state enum.
package regfile_seq_pkg;

   localparam logic [7:0]  TAP8  = 8'hB8;
   localparam logic [15:0] TAP16 = 16'hB400;

`ifdef REGFILE_SEQ_REG0_CHECK_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_ZW,
      S_FILL,
      S_CHECK,
      S_DONE
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_CHECK,
      S_DONE
   } state_t;
`endif

   function automatic logic [15:0] tap_mask(input int w);
      return (w == 16) ? TAP16 : {8'h00, TAP8};
   endfunction

endpackage

// File: rtl/regfile_sequencer_lfsr.sv
// Right-shifting Galois LFSR; a zero seed is replaced by 1 so the
// sequence can never lock up at zero.
module lfsr_galois
   import regfile_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] seed,
   input  logic         step,
   output logic [W-1:0] q
);

   localparam logic [15:0]  MASK16 = tap_mask(W);
   localparam logic [W-1:0] MASK   = MASK16[W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= W'(1);
      end else if (load) begin
         q <= (seed == '0) ? W'(1) : seed;
      end else if (step) begin
         q <= (q >> 1) ^ (q[0] ? MASK : '0);
      end
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Fills registers 1..2**N-1 with an LFSR sequence, then reads them back.
// REGFILE_SEQ_REG0_CHECK_EN adds a reg0 write-protect probe (ZW + rs2).
module regfile_sequencer
   import regfile_seq_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] seed,
   output logic         we,
   output logic [N-1:0] addr_rd,
   output logic [W-1:0] data_in,
   output logic [N-1:0] addr_rs1,
   output logic [N-1:0] addr_rs2,
   input  logic [W-1:0] rs1,
   input  logic [W-1:0] rs2,
   output logic         busy,
   output logic         done,
   output logic [N:0]   err_cnt,
   output logic         pass
);

   localparam logic [N-1:0] A_LAST = {N{1'b1}};
   localparam logic [N:0]   E_MAX  = {(N+1){1'b1}};

   state_t       state;
   state_t       state_nx;
   logic [N-1:0] a;
   logic [W-1:0] seed_q;
   logic [N:0]   err_q;
   logic         ran;
   logic         a_end;
   logic         miss;
   logic         lfsr_load;
   logic         lfsr_step;
   logic [W-1:0] lfsr_seed;
   logic [W-1:0] q;

   lfsr_galois #(.W(W)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .seed (lfsr_seed),
      .step (lfsr_step),
      .q    (q)
   );

   assign a_end    = (a == A_LAST);
   assign busy     = (state != S_IDLE);
   assign err_cnt  = err_q;
   assign pass     = ran && (err_q == '0);
   assign addr_rs2 = '0;

`ifndef REGFILE_SEQ_REG0_CHECK_EN
   logic unused_rs2;
   assign unused_rs2 = ^rs2;
`endif

   always_comb begin
      state_nx  = state;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      lfsr_seed = seed_q;
      we        = 1'b0;
      addr_rd   = '0;
      data_in   = '0;
      addr_rs1  = '0;
      done      = 1'b0;
      miss      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               lfsr_load = 1'b1;
               lfsr_seed = seed;
`ifdef REGFILE_SEQ_REG0_CHECK_EN
               state_nx  = S_ZW;
`else
               state_nx  = S_FILL;
`endif
            end
         end
`ifdef REGFILE_SEQ_REG0_CHECK_EN
         S_ZW: begin
            we       = 1'b1;
            data_in  = '1;
            state_nx = S_FILL;
         end
`endif
         S_FILL: begin
            we      = 1'b1;
            addr_rd = a;
            data_in = q;
            // CHECK must replay the sequence from the captured seed
            if (a_end) begin
               lfsr_load = 1'b1;
               state_nx  = S_CHECK;
            end else begin
               lfsr_step = 1'b1;
            end
         end
         S_CHECK: begin
            addr_rs1  = a;
            lfsr_step = 1'b1;
`ifdef REGFILE_SEQ_REG0_CHECK_EN
            miss      = (rs1 != q) || (rs2 != '0);
`else
            miss      = (rs1 != q);
`endif
            if (a_end) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a      <= '0;
         seed_q <= '0;
         err_q  <= '0;
         ran    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            seed_q <= seed;
            err_q  <= '0;
            ran    <= 1'b0;
            a      <= N'(1);
         end
         if (state == S_FILL) begin
            a <= a_end ? N'(1) : a + N'(1);
         end
         if (state == S_CHECK) begin
            a <= a + N'(1);
            if (miss && err_q != E_MAX) begin
               err_q <= err_q + (N+1)'(1);
            end
            if (a_end) begin
               ran <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file
// and a cycle-indexed run model (REGFILE_SEQ_REG0_CHECK_EN aware).
module tb_regfile_sequencer;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int NREG = (1 << N) - 1;
`ifdef REGFILE_SEQ_REG0_CHECK_EN
   localparam int OFF  = 1;
`else
   localparam int OFF  = 0;
`endif
   localparam int LAST = OFF + 2 * NREG + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] seed;
   logic         we;
   logic [N-1:0] addr_rd;
   logic [W-1:0] data_in;
   logic [N-1:0] addr_rs1;
   logic [N-1:0] addr_rs2;
   logic [W-1:0] rs1;
   logic [W-1:0] rs2;
   logic         busy;
   logic         done;
   logic [N:0]   err_cnt;
   logic         pass;

   int total = 0;
   int bad   = 0;
   bit armed = 1'b0;
   bit prot  = 1'b1;
   bit corrupt = 1'b0;

   logic [W-1:0] rf [16];
   logic [W-1:0] rf_save [16];

   regfile_sequencer #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .seed     (seed),
      .we       (we),
      .addr_rd  (addr_rd),
      .data_in  (data_in),
      .addr_rs1 (addr_rs1),
      .addr_rs2 (addr_rs2),
      .rs1      (rs1),
      .rs2      (rs2),
      .busy     (busy),
      .done     (done),
      .err_cnt  (err_cnt),
      .pass     (pass)
   );

   always #5 clk = ~clk;

   // behavioural register file; prot models a hardwired-zero reg0
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else if (we && !(prot && addr_rd == '0)) begin
         rf[addr_rd] <= data_in;
      end
   end

   assign rs1 = (prot && addr_rs1 == '0) ? '0 :
                (corrupt && addr_rs1 == 4'd5) ? '0 : rf[addr_rs1];
   assign rs2 = (prot && addr_rs2 == '0) ? '0 :
                (corrupt && addr_rs2 == 4'd5) ? '0 : rf[addr_rs2];

   function automatic logic [W-1:0] rdm(input int ad);
      if (prot && ad == 0) return '0;
      if (corrupt && ad == 5) return '0;
      return rf[ad];
   endfunction

   function automatic logic [W-1:0] lstep(input logic [W-1:0] x);
      return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
   endfunction

   function automatic logic [W-1:0] exp_data(input logic [W-1:0] s,
                                             input int idx);
      logic [W-1:0] v;
      v = (s == '0) ? 8'h01 : s;
      for (int i = 1; i < idx; i++) v = lstep(v);
      return v;
   endfunction

   // run model: mt = cycles since the accepted start edge, 0 when idle
   int           mt = 0;
   int           merr = 0;
   bit           mran = 1'b0;
   logic [W-1:0] mseed;

   always @(posedge clk) begin : model
      int  ad;
      bit  miss;
      if (rst) begin
         mt   <= 0;
         merr <= 0;
         mran <= 1'b0;
      end else if (mt == 0) begin
         if (start) begin
            mt    <= 1;
            mseed <= seed;
            merr  <= 0;
            mran  <= 1'b0;
         end
      end else begin
         if (mt >= OFF + NREG + 1 && mt <= OFF + 2 * NREG) begin
            ad   = mt - OFF - NREG;
            miss = (rdm(ad) != exp_data(mseed, ad));
`ifdef REGFILE_SEQ_REG0_CHECK_EN
            miss = miss || (rdm(0) != '0);
`endif
            if (miss && merr < 31) merr <= merr + 1;
            if (ad == NREG) mran <= 1'b1;
         end
         mt <= (mt == LAST) ? 0 : mt + 1;
      end
   end

   initial begin : compare
      logic         e_we;
      logic [N-1:0] e_rd;
      logic [W-1:0] e_din;
      logic [N-1:0] e_rs1;
      logic [28:0]  act;
      logic [28:0]  exp_v;
      forever begin
         @(negedge clk);
         if (armed) begin
            e_we  = 1'b0;
            e_rd  = '0;
            e_din = '0;
            e_rs1 = '0;
            if (OFF == 1 && mt == 1) begin
               e_we  = 1'b1;
               e_din = '1;
            end
            if (mt >= OFF + 1 && mt <= OFF + NREG) begin
               e_we  = 1'b1;
               e_rd  = N'(mt - OFF);
               e_din = exp_data(mseed, mt - OFF);
            end
            if (mt >= OFF + NREG + 1 && mt <= OFF + 2 * NREG)
               e_rs1 = N'(mt - OFF - NREG);
            act   = {we, addr_rd, data_in, addr_rs1, addr_rs2,
                     busy, done, err_cnt, pass};
            exp_v = {e_we, e_rd, e_din, e_rs1, 4'd0,
                     (mt != 0), (mt == LAST), 5'(merr),
                     (mran && merr == 0)};
            total++;
            if (act !== exp_v) begin
               bad++;
               $display("FAIL cycle t=%0d got=%h want=%h",
                        mt, act, exp_v);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // start a run, optionally pulse start/rst at cycle j, watch for done
   task automatic run(input logic [W-1:0] s, input int pulse_at,
                      input int rst_at, output int dcyc, output int nd);
      @(negedge clk);
      start = 1'b1;
      seed  = s;
      @(negedge clk);
      start = 1'b0;
      nd    = 0;
      dcyc  = -1;
      for (int j = 1; j <= LAST + 40; j++) begin
         if (done) begin
            nd++;
            if (dcyc < 0) dcyc = j;
         end
         if (rst_at > 0 && j == rst_at + 1) begin
            chk("rst_mid_we", we, 0);
            chk("rst_mid_busy", busy, 0);
         end
         start = (j == pulse_at);
         rst   = (j == rst_at);
         @(negedge clk);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      int dc;
      int nd;
      int diffs;
      rst   = 1'b1;
      start = 1'b0;
      seed  = '0;
      repeat (3) @(negedge clk);
      chk("reset_we", we, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err_cnt, 0);
      chk("reset_pass", pass, 0);
      chk("reset_addr", {addr_rd, addr_rs1, addr_rs2, data_in}, 0);
      armed = 1'b1;
      rst   = 1'b0;

      run(8'h01, -1, -1, dc, nd);
      chk("t1_latency", dc, LAST);
      chk("t1_ndone", nd, 1);
      chk("t1_err", err_cnt, 0);
      chk("t1_pass", pass, 1);
      chk("t1_rf1", rf[1], 8'h01);
      chk("t1_rf2", rf[2], 8'hB8);
      chk("t1_rf3", rf[3], 8'h5C);
      for (int i = 0; i < 16; i++) rf_save[i] = rf[i];

      corrupt = 1'b1;
      run(8'h01, -1, -1, dc, nd);
      chk("t2_err", err_cnt, 1);
      chk("t2_pass", pass, 0);
      corrupt = 1'b0;

      run(8'h00, -1, -1, dc, nd);
      diffs = 0;
      for (int i = 0; i < 16; i++) if (rf[i] !== rf_save[i]) diffs++;
      chk("t3_same_rf", diffs, 0);
      chk("t3_err", err_cnt, 0);
      chk("t3_pass", pass, 1);

      run(8'h01, -1, 10, dc, nd);
      chk("t4_no_done", nd, 0);
      chk("t4_err", err_cnt, 0);
      run(8'h5A, -1, -1, dc, nd);
      chk("t4_rerun_done", nd, 1);
      chk("t4_rerun_pass", pass, 1);

      run(8'h33, OFF + NREG + 5, -1, dc, nd);
      chk("t5_ndone", nd, 1);
      chk("t5_latency", dc, LAST);
      chk("t5_pass", pass, 1);

`ifdef REGFILE_SEQ_REG0_CHECK_EN
      prot = 1'b0;
      run(8'h01, -1, -1, dc, nd);
      chk("zw_noprot_err", err_cnt, 15);
      chk("zw_noprot_pass", pass, 0);
      prot = 1'b1;
      run(8'h01, -1, -1, dc, nd);
      chk("zw_prot_err", err_cnt, 0);
      chk("zw_prot_pass", pass, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: register-file address bits; 2**N registers.
REQ-002 SHALL have parameter W, default 8: data width; legal values 8 or 16 only.
REQ-003 SHALL have port clk  in  1: single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1: begin one fill/check run; sampled only in IDLE.
REQ-006 SHALL have port seed  in  W: LFSR seed, captured when start is accepted.
REQ-007 SHALL have port we  out  1: write enable to the register file.
REQ-008 SHALL have port addr_rd  out  N: write address.
REQ-009 SHALL have port data_in  out  W: write data.
REQ-010 SHALL have port addr_rs1  out  N: read address 1.
REQ-011 SHALL have port addr_rs2  out  N: read address 2.
REQ-012 SHALL have port rs1  in  W: read data 1, combinational from the register file.
REQ-013 SHALL have port rs2  in  W: read data 2, combinational from the register file.
REQ-014 SHALL have port busy  out  1: high in any state other than IDLE.
REQ-015 SHALL have port done  out  1: one-cycle pulse at run end.
REQ-016 SHALL have port err_cnt  out  N+1: mismatches counted in the last run, saturating.
REQ-017 SHALL have port pass  out  1: high when err_cnt==0 and at least one run has completed.

Function
REQ-018 SHALL implement FSM IDLE->FILL->CHECK->DONE->IDLE, plus ZW when the macro of REQ-031 is defined.
REQ-019 SHALL, in IDLE with start=1, load LFSR with seed (0 replaced by 1), clear err_cnt, and go to FILL next cycle.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 SHALL, in FILL, drive we=1, addr_rd=a, data_in=LFSR, for a=1..2**N-1, one address per cycle, stepping LFSR after each write.
REQ-022 SHALL step a W-bit Galois LFSR right-shift with tap mask 8'hB8 (W=8) or 16'hB400 (W=16).
REQ-023 SHALL, on leaving FILL, reload LFSR with the captured seed.
REQ-024 SHALL, in CHECK, drive addr_rs1=a for a=1..2**N-1, compare rs1 to LFSR in the same cycle, and increment err_cnt on mismatch, saturating at 2**(N+1)-1.
REQ-025 SHALL step the LFSR once per CHECK cycle, so FILL and CHECK each take 2**N-1 cycles.
REQ-026 SHALL hold we=0 in all states except FILL and ZW.
REQ-027 SHALL, with start at edge k, be in FILL for cycles k+1..k+15 and CHECK for k+16..k+30, and pulse done at k+31 (N=4, macro undefined).
REQ-028 SHALL drive addr_rs2=0 at all times; rs2 is ignored unless the macro of REQ-031 is defined.

Reset
REQ-029 SHALL, on rst, force state IDLE and drive we=0, busy=0, done=0, err_cnt=0, pass=0, all address outputs 0, data_in=0, and LFSR=1.
REQ-030 SHALL abort a run on rst mid-operation, without a done pulse and with no further writes.

Configuration
REQ-031 SHALL, with macro REGFILE_SEQ_REG0_CHECK_EN defined, insert one ZW cycle before FILL driving we=1, addr_rd=0, data_in=all-ones, and in CHECK also count a mismatch whenever rs2!=0.
REQ-032 SHALL, without REGFILE_SEQ_REG0_CHECK_EN, have no ZW state and ignore rs2; the start-to-done latency is then 2**(N+1)-1 cycles.

Structure
REQ-033 SHALL place the state enum and the LFSR tap-mask constants in package regfile_seq_pkg.
REQ-034 SHALL implement the LFSR as sub-module lfsr_galois, with parameter W and ports load, seed, step, and q.

Verification
REQ-035 SHALL cover: N=4, W=8, seed=8'h01, behavioral register file -> 15 writes, 1st data 8'h01, 2nd 8'hB8, done at k+31, err_cnt=0, pass=1.
REQ-036 SHALL cover: model corrupts reg 5 to 8'h00 after FILL -> err_cnt=1, pass=0.
REQ-037 SHALL cover: seed=0 -> behaves identically to seed=8'h01.
REQ-038 SHALL cover: rst asserted at k+10 -> we=0 next cycle, busy=0, no done pulse; a new start runs cleanly.
REQ-039 SHALL cover: start pulsed during CHECK -> ignored, and done occurs exactly once.
REQ-040 SHALL cover, with REGFILE_SEQ_REG0_CHECK_EN: model lacking reg0 protection -> err_cnt=15; correct model -> err_cnt=0.
